// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: shares the bridge port between m0 (CPU) and m1 (DMA/debug), one access per two cycles
module sys_bus_arbiter #(
    parameter bit          RR_EN   = 1'b1,
    parameter logic [31:0] DM_MAX  = 32'h0000_2fff,
    parameter logic [31:0] DEV_MIN = 32'h0000_7f00,
    parameter logic [31:0] DEV_MAX = 32'h0000_7f23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] br_addr,
    output logic [31:0] br_wdata,
    output logic [3:0]  br_byteen,
    input  logic [31:0] br_rdata,
    output logic        busy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]  r_state;
    logic        r_owner;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_byteen;
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        r_err0;
    logic        r_err1;

    logic        w_arb;
    logic        w_pick1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_grant;
    logic        w_mapped;

    // Arbitration runs in IDLE and RESP; grants are masked while reset is asserted so outputs stay 0
    assign w_arb    = rst_n && (r_state == S_IDLE || r_state == S_RESP);
    // m1 wins when alone, or on a tie when round-robin is on and m0 owned the last access
    assign w_pick1  = m1_req && (!m0_req || (RR_EN && !r_owner));
    assign w_gnt1   = w_arb && w_pick1;
    assign w_gnt0   = w_arb && m0_req && !w_pick1;
    assign w_grant  = w_gnt0 || w_gnt1;
    assign w_mapped = (r_addr <= DM_MAX) || (r_addr >= DEV_MIN && r_addr <= DEV_MAX);

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = r_rvalid0;
    assign m1_rvalid = r_rvalid1;
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;
    assign m0_err    = r_err0;
    assign m1_err    = r_err1;
    assign br_addr   = r_addr;
    assign br_wdata  = r_wdata;
    assign br_byteen = (r_state == S_ACCESS && w_mapped) ? r_byteen : 4'h0;
    assign busy      = r_state != S_IDLE;

    // State sequencing: a grant always leads to ACCESS, ACCESS always to RESP, otherwise back to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_grant ? S_ACCESS : (r_state == S_ACCESS ? S_RESP : S_IDLE);
        end
    end

    // Capture the winner's request fields; the owner doubles as last_owner for round-robin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner  <= 1'b1;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_byteen <= 4'h0;
        end else if (w_grant) begin
            r_owner  <= w_gnt1;
            r_addr   <= w_gnt1 ? m1_addr : m0_addr;
            r_wdata  <= w_gnt1 ? m1_wdata : m0_wdata;
            r_byteen <= w_gnt1 ? m1_byteen : m0_byteen;
        end
    end

    // Return read data and error to the owner at the end of RESP; rvalid appears the cycle after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= 32'h0;
            r_rdata1  <= 32'h0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            r_rvalid0 <= r_state == S_RESP && !r_owner;
            r_rvalid1 <= r_state == S_RESP && r_owner;
            if (r_state == S_RESP && !r_owner) begin
                r_rdata0 <= w_mapped ? br_rdata : 32'h0;
                r_err0   <= !w_mapped;
            end
            if (r_state == S_RESP && r_owner) begin
                r_rdata1 <= w_mapped ? br_rdata : 32'h0;
                r_err1   <= !w_mapped;
            end
        end
    end
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: cycle-table and hand-written sequences for both arbitration modes
module tb_sys_bus_arbiter;
    localparam logic [31:0] X  = 32'h5A5A_5A5A;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] CF = 32'hCAFE_F00D;
    localparam logic [31:0] A  = 32'hAAAA_0000;
    localparam logic [31:0] R1 = 32'h1234_5678;
    localparam logic [31:0] R2 = 32'h0BAD_0001;

    typedef struct {
        logic r0; logic [31:0] a0; logic [3:0] b0;
        logic r1; logic [31:0] a1; logic [3:0] b1;
        logic [31:0] rd;
        logic g0; logic g1; logic [3:0] bbe; logic [31:0] ba; logic [31:0] bw; logic bsy;
        logic v0; logic v1; logic e0; logic e1; logic [31:0] d0; logic [31:0] d1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
    logic [31:0] m0_wdata = DB, m1_wdata = CF;
    logic [3:0]  m0_byteen = 4'h0, m1_byteen = 4'h0;
    logic [31:0] br_rdata = X;

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, busy;
    logic [31:0] m0_rdata, m1_rdata, br_addr, br_wdata;
    logic [3:0]  br_byteen;
    logic        f_m0_gnt, f_m1_gnt, f_m0_rvalid, f_m1_rvalid, f_m0_err, f_m1_err, f_busy;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_br_addr, f_br_wdata;
    logic [3:0]  f_br_byteen;

    int checks = 0;
    int failures = 0;
    vec_t v[29];

    always #5 clk = ~clk;

    sys_bus_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .br_addr(br_addr), .br_wdata(br_wdata), .br_byteen(br_byteen), .br_rdata(br_rdata),
        .busy(busy)
    );

    sys_bus_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
        .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
        .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
        .br_addr(f_br_addr), .br_wdata(f_br_wdata), .br_byteen(f_br_byteen), .br_rdata(br_rdata),
        .busy(f_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    initial begin
        v[0]  = '{0,0,0, 0,0,0, X,      0,0,4'h0,32'h0,   32'h0,0, 0,0,0,0, 32'h0,32'h0};
        v[1]  = '{1,32'h100,4'hF, 0,0,0, X, 1,0,4'h0,32'h0, 32'h0,0, 0,0,0,0, 32'h0,32'h0};
        v[2]  = '{0,0,0, 0,0,0, X,      0,0,4'hF,32'h100, DB,1,    0,0,0,0, 32'h0,32'h0};
        v[3]  = '{0,0,0, 0,0,0, A,      0,0,4'h0,32'h100, DB,1,    0,0,0,0, 32'h0,32'h0};
        v[4]  = '{0,0,0, 0,0,0, X,      0,0,4'h0,32'h100, DB,0,    1,0,0,0, A,32'h0};
        v[5]  = '{0,0,0, 1,32'h7f04,4'h0, X, 0,1,4'h0,32'h100, DB,0, 0,0,0,0, A,32'h0};
        v[6]  = '{0,0,0, 0,0,0, X,      0,0,4'h0,32'h7f04, CF,1,   0,0,0,0, A,32'h0};
        v[7]  = '{0,0,0, 0,0,0, R1,     0,0,4'h0,32'h7f04, CF,1,   0,0,0,0, A,32'h0};
        v[8]  = '{0,0,0, 0,0,0, X,      0,0,4'h0,32'h7f04, CF,0,   0,1,0,0, A,R1};
        v[9]  = '{1,32'h5000,4'hF, 0,0,0, X, 1,0,4'h0,32'h7f04, CF,0, 0,0,0,0, A,R1};
        v[10] = '{0,0,0, 0,0,0, X,      0,0,4'h0,32'h5000, DB,1,   0,0,0,0, A,R1};
        v[11] = '{0,0,0, 0,0,0, 32'hFFFF_FFFF, 0,0,4'h0,32'h5000, DB,1, 0,0,0,0, A,R1};
        v[12] = '{0,0,0, 0,0,0, X,      0,0,4'h0,32'h5000, DB,0,   1,0,1,0, 32'h0,R1};
        v[13] = '{0,0,0, 1,32'h2fff,4'h3, X, 0,1,4'h0,32'h5000, DB,0, 0,0,0,0, 32'h0,R1};
        v[14] = '{0,0,0, 0,0,0, X,      0,0,4'h3,32'h2fff, CF,1,   0,0,0,0, 32'h0,R1};
        v[15] = '{0,0,0, 0,0,0, R2,     0,0,4'h0,32'h2fff, CF,1,   0,0,0,0, 32'h0,R1};
        v[16] = '{0,0,0, 0,0,0, X,      0,0,4'h0,32'h2fff, CF,0,   0,1,0,0, 32'h0,R2};
        v[17] = '{0,0,0, 1,32'h7f24,4'hF, X, 0,1,4'h0,32'h2fff, CF,0, 0,0,0,0, 32'h0,R2};
        v[18] = '{0,0,0, 0,0,0, X,      0,0,4'h0,32'h7f24, CF,1,   0,0,0,0, 32'h0,R2};
        v[19] = '{0,0,0, 0,0,0, 32'h1111_1111, 0,0,4'h0,32'h7f24, CF,1, 0,0,0,0, 32'h0,R2};
        v[20] = '{0,0,0, 0,0,0, X,      0,0,4'h0,32'h7f24, CF,0,   0,1,0,1, 32'h0,32'h0};
        v[21] = '{1,32'h10,4'h1, 1,32'h7f00,4'hF, X,  1,0,4'h0,32'h7f24, CF,0, 0,0,0,0, 32'h0,32'h0};
        v[22] = '{1,32'h10,4'h1, 1,32'h7f00,4'hF, X,  0,0,4'h1,32'h10, DB,1, 0,0,0,0, 32'h0,32'h0};
        v[23] = '{1,32'h10,4'h1, 1,32'h7f00,4'hF, 32'h22, 0,1,4'h0,32'h10, DB,1, 0,0,0,0, 32'h0,32'h0};
        v[24] = '{1,32'h10,4'h1, 1,32'h7f00,4'hF, X,  0,0,4'hF,32'h7f00, CF,1, 1,0,0,0, 32'h22,32'h0};
        v[25] = '{1,32'h10,4'h1, 1,32'h7f00,4'hF, 32'h33, 1,0,4'h0,32'h7f00, CF,1, 0,0,0,0, 32'h22,32'h0};
        v[26] = '{1,32'h10,4'h1, 1,32'h7f00,4'hF, X,  0,0,4'h1,32'h10, DB,1, 0,1,0,0, 32'h22,32'h33};
        v[27] = '{0,0,0, 0,0,0, 32'h44, 0,0,4'h0,32'h10, DB,1,     0,0,0,0, 32'h22,32'h33};
        v[28] = '{0,0,0, 0,0,0, X,      0,0,4'h0,32'h10, DB,0,     1,0,0,0, 32'h44,32'h33};

        // Reset state with a request pending: gnt must stay low
        m0_req = 1'b1;
        #12;
        chk("rst_m0_gnt", {31'h0, m0_gnt}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_br_addr", br_addr, 32'h0);
        chk("rst_br_byteen", {28'h0, br_byteen}, 32'h0);
        chk("rst_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
        m0_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            if (i > 0) @(negedge clk);
            m0_req = v[i].r0; m0_addr = v[i].a0; m0_byteen = v[i].b0;
            m1_req = v[i].r1; m1_addr = v[i].a1; m1_byteen = v[i].b1;
            br_rdata = v[i].rd;
            #1;
            chk($sformatf("v%0d_m0_gnt", i), {31'h0, m0_gnt}, {31'h0, v[i].g0});
            chk($sformatf("v%0d_m1_gnt", i), {31'h0, m1_gnt}, {31'h0, v[i].g1});
            chk($sformatf("v%0d_br_byteen", i), {28'h0, br_byteen}, {28'h0, v[i].bbe});
            chk($sformatf("v%0d_br_addr", i), br_addr, v[i].ba);
            chk($sformatf("v%0d_br_wdata", i), br_wdata, v[i].bw);
            chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, v[i].bsy});
            chk($sformatf("v%0d_m0_rvalid", i), {31'h0, m0_rvalid}, {31'h0, v[i].v0});
            chk($sformatf("v%0d_m1_rvalid", i), {31'h0, m1_rvalid}, {31'h0, v[i].v1});
            chk($sformatf("v%0d_m0_rdata", i), m0_rdata, v[i].d0);
            chk($sformatf("v%0d_m1_rdata", i), m1_rdata, v[i].d1);
            if (v[i].v0) chk($sformatf("v%0d_m0_err", i), {31'h0, m0_err}, {31'h0, v[i].e0});
            if (v[i].v1) chk($sformatf("v%0d_m1_err", i), {31'h0, m1_err}, {31'h0, v[i].e1});
        end

        // Continuous contention: RR alternates (last owner m0 -> m1 first), fixed priority always m0
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            m0_req = k < 8; m0_addr = 32'h20; m0_byteen = 4'hF;
            m1_req = k < 9; m1_addr = 32'h24; m1_byteen = 4'hF;
            br_rdata = X;
            #1;
            chk($sformatf("rr%0d_m0_gnt", k), {31'h0, m0_gnt}, {31'h0, k < 8 && k % 4 == 2});
            chk($sformatf("rr%0d_m1_gnt", k), {31'h0, m1_gnt}, {31'h0, k % 4 == 0 && k < 9});
            chk($sformatf("fp%0d_m0_gnt", k), {31'h0, f_m0_gnt}, {31'h0, k < 8 && k % 2 == 0});
            chk($sformatf("fp%0d_m1_gnt", k), {31'h0, f_m1_gnt}, {31'h0, k == 8});
        end
        m1_req = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("drain_busy", {31'h0, busy}, 32'h0);
        chk("drain_fp_busy", {31'h0, f_busy}, 32'h0);

        // Reset asserted in the middle of ACCESS, request still held
        m0_req = 1'b1; m0_addr = 32'h200; m0_byteen = 4'hF;
        #1;
        chk("ra_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        @(negedge clk);
        #1;
        chk("ra_access_byteen", {28'h0, br_byteen}, 32'hF);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ra_br_byteen", {28'h0, br_byteen}, 32'h0);
        chk("ra_fp_br_byteen", {28'h0, f_br_byteen}, 32'h0);
        chk("ra_m0_gnt_low", {31'h0, m0_gnt}, 32'h0);
        chk("ra_m1_gnt_low", {31'h0, m1_gnt}, 32'h0);
        chk("ra_busy", {31'h0, busy}, 32'h0);
        chk("ra_br_addr", br_addr, 32'h0);
        chk("ra_br_wdata", br_wdata, 32'h0);
        chk("ra_m0_rdata", m0_rdata, 32'h0);
        @(negedge clk);
        m0_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("ra%0d_m0_rvalid", k), {31'h0, m0_rvalid}, 32'h0);
            chk($sformatf("ra%0d_busy", k), {31'h0, busy}, 32'h0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
